pconv_feeder: RTL and testbench

Transmit side of the pointwise-conv pixel stream. Captures one complete feature map of CHANNEL-wide pixels written by the previous layer. On start, streams the pixels in raster order, one per cycle, on a valid/ready interface; this interface drives the pconv input_vld/input_din pins. After the last pixel it waits for the downstream conv's end flag before reporting done, so the next frame cannot overrun the conv.

---
 rtl/pconv_feeder_pkg.sv | 15 +
 rtl/pconv_feeder_fmap_buf.sv | 36 +++
 rtl/pconv_feeder.sv | 155 +++++++++++++++
 tb/tb_pconv_feeder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pconv_feeder_pkg.sv
// Shared definitions for the pointwise-conv pixel feeder.
// Holds the default data geometry and the feeder FSM state encoding.
package pconv_feeder_pkg;

  localparam int N_DEFAULT          = 16;  // bits per channel element
  localparam int CHANNEL_DEFAULT    = 6;   // channels per pixel
  localparam int INPUT_SIZE_DEFAULT = 6;   // feature-map side length

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,  // filling the buffer, waiting for start
    ST_STREAM   = 2'd1,  // presenting pixels to the conv
    ST_WAIT_END = 2'd2   // all pixels taken, waiting for conv_end
  } feeder_state_t;

endpackage

// File: rtl/pconv_feeder_fmap_buf.sv
// Feature-map buffer: DEPTH x W register array.
// Ports:
//   clk      - clock
//   i_we     - write enable (synchronous write)
//   i_waddr  - write address
//   i_wdata  - write data
//   i_raddr  - read address (asynchronous read)
//   o_rdata  - read data; zero for addresses past the last entry
module pconv_feeder_fmap_buf #(
  parameter int W     = 96,
  parameter int DEPTH = 36,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we && (i_waddr <= LAST_ADDR)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // The read counter can sit one past the last entry while the final
  // pixel is on the output; that address must not index the array.
  assign o_rdata = (i_raddr <= LAST_ADDR) ? r_mem[i_raddr] : '0;

endmodule

// File: rtl/pconv_feeder.sv
// Transmit side of the pointwise-conv pixel stream.
// Captures one feature map written by the previous layer, then on start
// streams it in raster order and waits for the conv end flag before done.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   wr_vld/din  - pixel write from upstream layer; wr_full when frame held
//   start       - stream request (accepted only when wr_full)
//   busy, done  - busy from accepted start until the one-cycle done pulse
//   pix_*       - output stream towards conv input_vld/input_din
//   conv_end    - downstream conv_dout_end
//   dbg_state   - current FSM state
// Handshake: a pixel transfers on a cycle where pix_vld && pix_ready;
// once pix_vld is high, pix_vld and pix_dout stay stable until transfer.
module pconv_feeder
  import pconv_feeder_pkg::*;
#(
  parameter int N          = N_DEFAULT,
  parameter int CHANNEL    = CHANNEL_DEFAULT,
  parameter int INPUT_SIZE = INPUT_SIZE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_vld,
  input  logic [CHANNEL*N-1:0] wr_din,
  output logic                 wr_full,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 pix_vld,
  output logic [CHANNEL*N-1:0] pix_dout,
  input  logic                 pix_ready,
  input  logic                 conv_end,
  output feeder_state_t        dbg_state
);

  localparam int DEPTH = INPUT_SIZE * INPUT_SIZE;
  localparam int W     = CHANNEL * N;
  localparam int AW    = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] DEPTH_CNT = AW'(DEPTH);

  feeder_state_t r_state, w_state_nxt;
  logic [AW-1:0] r_wcnt, w_wcnt_nxt;
  logic [AW-1:0] r_rcnt, w_rcnt_nxt;
  logic          r_pix_vld, w_pix_vld_nxt;
  logic [W-1:0]  r_pix_dout, w_pix_dout_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_done, w_done_nxt;
  logic          r_wr_full, w_wr_full_nxt;
  logic          r_seen_low, w_seen_low_nxt;
  logic          w_we;
  logic [AW-1:0] w_raddr;
  logic [W-1:0]  w_rdata;

  // Entry 0 is needed on the start cycle; afterwards the read counter
  // points at the next pixel to present.
  assign w_raddr = (r_state == ST_IDLE) ? '0 : r_rcnt;

  pconv_feeder_fmap_buf #(
    .W     (W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wcnt),
    .i_wdata (wr_din),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_wcnt     <= '0;
      r_rcnt     <= '0;
      r_pix_vld  <= 1'b0;
      r_pix_dout <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_wr_full  <= 1'b0;
      r_seen_low <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wcnt     <= w_wcnt_nxt;
      r_rcnt     <= w_rcnt_nxt;
      r_pix_vld  <= w_pix_vld_nxt;
      r_pix_dout <= w_pix_dout_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_wr_full  <= w_wr_full_nxt;
      r_seen_low <= w_seen_low_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wcnt_nxt     = r_wcnt;
    w_rcnt_nxt     = r_rcnt;
    w_pix_vld_nxt  = r_pix_vld;
    w_pix_dout_nxt = r_pix_dout;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_wr_full_nxt  = r_wr_full;
    w_we           = 1'b0;
    // conv_end idles high, so a frame may only end after it has been
    // seen low at some point during this frame.
    w_seen_low_nxt = r_seen_low | (r_busy & ~conv_end);

    unique case (r_state)
      ST_IDLE: begin
        if (start && r_wr_full) begin
          w_pix_dout_nxt = w_rdata;
          w_pix_vld_nxt  = 1'b1;
          w_rcnt_nxt     = AW'(1);
          w_busy_nxt     = 1'b1;
          w_seen_low_nxt = 1'b0;
          w_state_nxt    = ST_STREAM;
        end else if (wr_vld && (r_wcnt < DEPTH_CNT)) begin
          w_we          = 1'b1;
          w_wcnt_nxt    = r_wcnt + 1'b1;
          w_wr_full_nxt = (r_wcnt == (DEPTH_CNT - 1'b1));
        end
      end
      ST_STREAM: begin
        if (r_pix_vld && pix_ready) begin
          if (r_rcnt < DEPTH_CNT) begin
            w_pix_dout_nxt = w_rdata;
            w_rcnt_nxt     = r_rcnt + 1'b1;
          end else begin
            w_pix_vld_nxt = 1'b0;
            w_state_nxt   = ST_WAIT_END;
          end
        end
      end
      ST_WAIT_END: begin
        if (conv_end && r_seen_low) begin
          w_done_nxt    = 1'b1;
          w_busy_nxt    = 1'b0;
          w_wcnt_nxt    = '0;
          w_wr_full_nxt = 1'b0;
          w_state_nxt   = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign wr_full   = r_wr_full;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pix_vld   = r_pix_vld;
  assign pix_dout  = r_pix_dout;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_pconv_feeder.sv
// Bench for pconv_feeder: random frames against a queue-based model of
// the frame (first DEPTH written pixels, streamed in write order).
module tb_pconv_feeder;
  import pconv_feeder_pkg::*;

  localparam int N       = 16;
  localparam int CHANNEL = 6;
  localparam int W       = N * CHANNEL;
  localparam int DEPTH   = 36;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         wr_vld = 1'b0;
  logic [W-1:0] wr_din = '0;
  logic         wr_full;
  logic         start = 1'b0;
  logic         busy;
  logic         done;
  logic         pix_vld;
  logic [W-1:0] pix_dout;
  logic         pix_ready = 1'b1;
  logic         conv_end = 1'b1;
  feeder_state_t dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int n_done_total = 0;
  logic [W-1:0] exp_q[$];

  pconv_feeder #(.N(N), .CHANNEL(CHANNEL), .INPUT_SIZE(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_vld    (wr_vld),
    .wr_din    (wr_din),
    .wr_full   (wr_full),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pix_vld   (pix_vld),
    .pix_dout  (pix_dout),
    .pix_ready (pix_ready),
    .conv_end  (conv_end),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_pix();
    return {$urandom, $urandom, $urandom};
  endfunction

  // Write n pixels; the model keeps only the first DEPTH of a frame.
  task automatic write_frame(input int n, input bit patterned, input bit start_on_last);
    for (int i = 0; i < n; i++) begin
      logic [W-1:0] px;
      px = rand_pix();
      if (patterned) begin
        for (int c = 0; c < CHANNEL; c++) px[c*N +: N] = N'(i * 8 + c);
      end
      wr_vld = 1'b1;
      wr_din = px;
      start  = start_on_last && (i == n - 1);
      if (exp_q.size() < DEPTH) exp_q.push_back(px);
      tick();
      check("wr_full", W'(wr_full), W'(exp_q.size() == DEPTH));
      if (start) check("start_with_fill_write", W'(busy), W'(1'b0));
    end
    wr_vld = 1'b0;
    start  = 1'b0;
  endtask

  // mode 0: ready=1, conv_end low 40 cycles from first pixel
  // mode 1: ready pattern 1,0,0,1, conv_end low 100 cycles
  // mode 2: ready=1, conv_end held high then pulsed low once
  task automatic run_stream(input int mode, input int abort_at);
    int got = 0, vld_cnt = 0, first_vld = -1, last_vld = -1;
    int rise = -100, drop = -1, post = 0, delay;
    bit fin = 1'b0;
    logic pv_prev = 1'b0, pr_prev = 1'b1;
    logic [W-1:0] pd_prev = '0;
    delay = (mode == 1) ? 100 : 40;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", W'(busy), W'(1'b1));
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (abort_at >= 0 && got == abort_at) begin
        wr_vld = 1'b0;
        rst_n  = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_vld", W'(pix_vld), W'(1'b0));
        check("abort_busy", W'(busy), W'(1'b0));
        check("abort_full", W'(wr_full), W'(1'b0));
        check("abort_dout", pix_dout, '0);
        conv_end = 1'b1;
        pix_ready = 1'b1;
        tick();
        check("abort_no_done", W'(done), W'(1'b0));
        exp_q.delete();
        return;
      end
      if (pv_prev && !pr_prev) begin
        check("hold_vld", W'(pix_vld), W'(1'b1));
        check("hold_dout", pix_dout, pd_prev);
      end
      if (pix_vld) begin
        vld_cnt++;
        if (first_vld < 0) first_vld = cyc;
        last_vld = cyc;
      end
      if (done) begin
        n_done_total++;
        check("done_time", W'(cyc), W'(rise + 1));
        check("busy_at_done", W'(busy), W'(1'b0));
        check("full_at_done", W'(wr_full), W'(1'b0));
        check("pix_count", W'(got), W'(DEPTH));
        fin = 1'b1;
        break;
      end
      pix_ready = (mode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (mode == 2) begin
        if (got == DEPTH && !pix_vld) post++;
        conv_end = (post != 6);
        if (post == 7) rise = cyc;
      end else begin
        if (drop < 0 && pix_vld) drop = cyc;
        conv_end = !(drop >= 0 && cyc < drop + delay);
        if (drop >= 0 && cyc == drop + delay) rise = cyc;
      end
      // writes during a frame must be ignored
      wr_vld = 1'($urandom_range(0, 1));
      wr_din = rand_pix();
      if (pix_vld && pix_ready) begin
        if (exp_q.size() == 0) check("extra_pixel", W'(1'b1), W'(1'b0));
        else check("pix_dout", pix_dout, exp_q.pop_front());
        got++;
      end
      pv_prev = pix_vld;
      pr_prev = pix_ready;
      pd_prev = pix_dout;
      tick();
    end
    wr_vld = 1'b0;
    conv_end = 1'b1;
    pix_ready = 1'b1;
    if (!fin) check("stream_timeout", W'(1'b0), W'(1'b1));
    if (mode != 1) begin
      check("first_vld", W'(first_vld), W'(0));
      check("vld_cycles", W'(vld_cnt), W'(DEPTH));
      check("last_vld", W'(last_vld), W'(DEPTH - 1));
    end
    tick();
    check("done_single", W'(done), W'(1'b0));
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_vld", W'(pix_vld), W'(1'b0));
    check("rst_dout", pix_dout, '0);
    check("rst_busy", W'(busy), W'(1'b0));
    check("rst_done", W'(done), W'(1'b0));
    check("rst_full", W'(wr_full), W'(1'b0));
    check("rst_state", W'(dbg_state), W'(ST_IDLE));
    rst_n = 1'b1;
    tick();

    // basic patterned frame
    write_frame(DEPTH, 1'b1, 1'b0);
    run_stream(0, -1);
    // backpressure
    write_frame(DEPTH, 1'b0, 1'b0);
    run_stream(1, -1);
    // early start, then overflow writes
    write_frame(20, 1'b0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("early_start_busy", W'(busy), W'(1'b0));
    check("early_start_vld", W'(pix_vld), W'(1'b0));
    write_frame(20, 1'b0, 1'b0);
    run_stream(0, -1);
    // stale end flag
    write_frame(DEPTH, 1'b0, 1'b0);
    run_stream(2, -1);
    // reset at pixel 10, then a fresh frame with start on the filling write
    write_frame(DEPTH, 1'b0, 1'b0);
    run_stream(0, 10);
    write_frame(DEPTH, 1'b0, 1'b1);
    run_stream(0, -1);
    // back-to-back refill
    write_frame(DEPTH, 1'b0, 1'b0);
    run_stream(0, -1);
    check("done_total", W'(n_done_total), W'(6));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
